// File: rtl/tm1638_pkg.sv
// Shared TM1638 protocol definitions: FSM states, command opcodes and mode-bit positions.
// Pure declarations: no logic, no latency, no flow control.
package tm1638_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    localparam int MODE_READ_BIT  = 1;
    localparam int MODE_FIXED_BIT = 2;
    localparam int DISP_ON_BIT    = 3;

endpackage

// File: rtl/tm1638_sync_edge.sv
// Synchronises one asynchronous pin into i_clk and flags its rising/falling edges.
// Latency: SYNC_STAGES cycles to level, edges valid for one cycle; no backpressure.
module tm1638_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
            prev_q <= IDLE_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 slave: decodes controller commands into a 16x8 display RAM, display control and key readback.
// Latency: pin edges act SYNC_STAGES+1 cycles late, RAM read port 1 cycle; no backpressure (protocol is master-paced).
import tm1638_pkg::*;

module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tm_stb,
    input  logic        i_tm_clk,
    input  logic        i_dio,
    output logic        o_dio,
    output logic        o_dio_oe,
    input  logic [31:0] i_keys,
    input  logic [3:0]  i_ram_addr,
    output logic [7:0]  o_ram_data,
    output logic        o_display_on,
    output logic [2:0]  o_brightness,
    output logic        o_frame_done
);

    logic stb_lvl, stb_rise, stb_fall;
    logic clk_unused_lvl, clk_rise, clk_fall;
    logic dio_lvl, dio_unused_rise, dio_unused_fall;

    tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_stb (
        .i_clk(i_clk), .i_rst(i_rst), .din(i_tm_stb),
        .level(stb_lvl), .rise(stb_rise), .fall(stb_fall)
    );
    tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_clk (
        .i_clk(i_clk), .i_rst(i_rst), .din(i_tm_clk),
        .level(clk_unused_lvl), .rise(clk_rise), .fall(clk_fall)
    );
    tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_dio (
        .i_clk(i_clk), .i_rst(i_rst), .din(i_dio),
        .level(dio_lvl), .rise(dio_unused_rise), .fall(dio_unused_fall)
    );

    state_t      state, state_d;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_q;
    logic [7:0]  byte_in;
    logic        byte_done;
    logic        saw_clk, armed;
    logic [1:0]  flush_cnt;
    logic [3:0]  pointer;
    logic        fixed_q, read_q;
    logic [31:0] keys_snap;
    logic [5:0]  rd_idx;
    logic        dio_q;
    logic        start_txn, cmd_done, ram_we, frame_pulse;
    logic [7:0]  ram [16];

    // Bits arrive LSB first, so the newest bit enters at the top of the byte.
    assign byte_in   = {dio_lvl, shift_q};
    assign byte_done = clk_rise && (bit_cnt == 3'd7) && (state != S_IDLE);

    always_comb begin
        state_d     = state;
        start_txn   = 1'b0;
        cmd_done    = 1'b0;
        ram_we      = 1'b0;
        frame_pulse = 1'b0;
        if (stb_rise) begin
            state_d     = S_IDLE;
            frame_pulse = (state != S_IDLE) && (saw_clk || clk_rise);
        end else begin
            case (state)
                S_IDLE: begin
                    if (stb_fall && armed) begin
                        state_d   = S_CMD;
                        start_txn = 1'b1;
                    end
                end
                S_CMD: begin
                    if (byte_done) begin
                        cmd_done = 1'b1;
                        case (byte_in[7:6])
                            CMD_DATA: state_d = byte_in[MODE_READ_BIT] ? S_RDATA : S_IGNORE;
                            CMD_ADDR: state_d = S_WDATA;
                            default:  state_d = S_IGNORE;
                        endcase
                    end
                end
                S_WDATA: ram_we = byte_done;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bit_cnt      <= 3'd0;
            shift_q      <= 7'd0;
            saw_clk      <= 1'b0;
            armed        <= 1'b0;
            flush_cnt    <= 2'd0;
            pointer      <= 4'd0;
            fixed_q      <= 1'b0;
            read_q       <= 1'b0;
            keys_snap    <= 32'd0;
            rd_idx       <= 6'd0;
            dio_q        <= 1'b1;
            o_display_on <= 1'b0;
            o_brightness <= 3'd0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= frame_pulse;
            // STB held low through reset must not look like a new transaction: wait for it to be seen high.
            if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 2'd1;
            else if (stb_lvl)      armed     <= 1'b1;

            if (start_txn || stb_rise) begin
                bit_cnt <= 3'd0;
                saw_clk <= 1'b0;
            end else if ((state != S_IDLE) && clk_rise) begin
                shift_q <= byte_in[7:1];
                bit_cnt <= bit_cnt + 3'd1;
                saw_clk <= 1'b1;
            end

            if (cmd_done) begin
                case (byte_in[7:6])
                    CMD_DATA: begin
                        read_q    <= byte_in[MODE_READ_BIT];
                        fixed_q   <= byte_in[MODE_FIXED_BIT];
                        keys_snap <= i_keys;
                        rd_idx    <= 6'd0;
                    end
                    CMD_DISP: begin
                        o_display_on <= byte_in[DISP_ON_BIT];
                        o_brightness <= byte_in[2:0];
                    end
                    CMD_ADDR: pointer <= byte_in[3:0];
                    default: ;
                endcase
            end
            if (ram_we && !fixed_q) pointer <= pointer + 4'd1;

            if (stb_rise) begin
                dio_q <= 1'b1;
            end else if ((state == S_RDATA) && clk_fall) begin
                if (rd_idx[5]) begin
                    dio_q <= 1'b1;
                end else begin
                    dio_q  <= keys_snap[rd_idx[4:0]];
                    rd_idx <= rd_idx + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (ram_we) ram[pointer] <= byte_in;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_ram_data <= 8'd0;
        else       o_ram_data <= ram[i_ram_addr];
    end

    assign o_dio    = dio_q;
    assign o_dio_oe = (state == S_RDATA) && read_q && !stb_rise;

endmodule

// File: tb/tb_tm1638_responder.sv
// Self-checking bench for tm1638_responder: directed protocol sequences, a display-control
// vector table and randomized transactions checked against a transaction-level model.
module tb_tm1638_responder;

    localparam int H = 5;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_tm_stb = 1'b1;
    logic        i_tm_clk = 1'b1;
    logic        i_dio = 1'b1;
    logic        o_dio, o_dio_oe;
    logic [31:0] i_keys = 32'd0;
    logic [3:0]  i_ram_addr = 4'd0;
    logic [7:0]  o_ram_data;
    logic        o_display_on;
    logic [2:0]  o_brightness;
    logic        o_frame_done;

    always #5 i_clk = ~i_clk;

    tm1638_responder #(.SYNC_STAGES(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_tm_stb(i_tm_stb), .i_tm_clk(i_tm_clk), .i_dio(i_dio),
        .o_dio(o_dio), .o_dio_oe(o_dio_oe),
        .i_keys(i_keys), .i_ram_addr(i_ram_addr), .o_ram_data(o_ram_data),
        .o_display_on(o_display_on), .o_brightness(o_brightness),
        .o_frame_done(o_frame_done)
    );

    int tests = 0;
    int fails = 0;
    int frame_cnt = 0;

    always @(negedge i_clk) if (o_frame_done) frame_cnt++;

    // Transaction-level model state
    logic [7:0] m_ram [16];
    logic [3:0] m_ptr = 4'd0;
    logic       m_fixed = 1'b0;
    logic       m_on = 1'b0;
    logic [2:0] m_br = 3'd0;
    logic [7:0] tx_q [$];

    typedef struct {
        logic [7:0] cmd;
        logic       exp_on;
        logic [2:0] exp_br;
    } disp_vec_t;
    disp_vec_t dtab [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            i_tm_clk = 1'b0;
            i_dio    = b[i];
            tick(H);
            i_tm_clk = 1'b1;
            tick(H);
        end
    endtask

    // Applies one whole transaction (all of tx_q) to the model.
    task automatic model_txn();
        logic [7:0] b0;
        if (tx_q.size() == 0) return;
        b0 = tx_q[0];
        case (b0[7:6])
            2'b01: m_fixed = b0[2];
            2'b10: begin m_on = b0[3]; m_br = b0[2:0]; end
            2'b11: begin
                m_ptr = b0[3:0];
                for (int i = 1; i < tx_q.size(); i++) begin
                    m_ram[m_ptr] = tx_q[i];
                    if (!m_fixed) m_ptr = m_ptr + 4'd1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic run_txn(input int pbits, input logic [7:0] pbyte);
        i_tm_stb = 1'b0;
        tick(H);
        foreach (tx_q[i]) send_bits(tx_q[i], 8);
        if (pbits > 0) send_bits(pbyte, pbits);
        i_dio    = 1'b1;
        i_tm_stb = 1'b1;
        tick(2 * H);
        model_txn();
    endtask

    task automatic rd_ram(input logic [3:0] a, output logic [7:0] d);
        i_ram_addr = a;
        tick(2);
        d = o_ram_data;
    endtask

    task automatic check_ram();
        logic [7:0] d;
        for (int a = 0; a < 16; a++) begin
            rd_ram(a[3:0], d);
            chk($sformatf("ram[%0d]", a), d, m_ram[a]);
        end
    endtask

    task automatic check_disp();
        chk("display_on", o_display_on, m_on);
        chk("brightness", o_brightness, m_br);
    endtask

    task automatic do_read(input logic [31:0] keys, output logic [31:0] got,
                           output int oe_bad, output logic tail_dio);
        i_keys   = keys;
        i_tm_stb = 1'b0;
        tick(H);
        send_bits(8'h42, 8);
        i_dio  = 1'b1;
        got    = 32'd0;
        oe_bad = 0;
        for (int k = 0; k < 32; k++) begin
            i_tm_clk = 1'b0;
            tick(H);
            got[k] = o_dio;
            if (!o_dio_oe) oe_bad++;
            i_tm_clk = 1'b1;
            tick(H);
        end
        i_tm_clk = 1'b0;
        tick(H);
        tail_dio = o_dio;
        if (!o_dio_oe) oe_bad++;
        i_tm_clk = 1'b1;
        tick(H);
        tx_q = {8'h42};
        model_txn();
    endtask

    task automatic end_read();
        int n = 0;
        i_tm_stb = 1'b1;
        while (o_dio_oe && n < 20) begin
            tick(1);
            n++;
        end
        chk("oe_fall", o_dio_oe, 1'b0);
        chk("oe_before_frame", o_frame_done, 1'b0);
        tick(1);
        chk("frame_after_oe", o_frame_done, 1'b1);
        tick(2 * H);
    endtask

    initial begin
        logic [7:0]  v, d;
        logic [31:0] got, keys;
        logic        tail;
        int          oe_bad, f0, n;

        dtab[0] = '{8'h8F, 1'b1, 3'd7};
        dtab[1] = '{8'h80, 1'b0, 3'd0};
        dtab[2] = '{8'h8A, 1'b1, 3'd2};
        dtab[3] = '{8'h3F, 1'b1, 3'd2};
        dtab[4] = '{8'h85, 1'b0, 3'd5};
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;

        // Reset state
        tick(2);
        chk("rst_oe", o_dio_oe, 1'b0);
        chk("rst_dio", o_dio, 1'b1);
        chk("rst_on", o_display_on, 1'b0);
        chk("rst_br", o_brightness, 3'd0);
        chk("rst_frame", o_frame_done, 1'b0);
        chk("rst_ramdata", o_ram_data, 8'd0);
        i_rst = 1'b0;
        tick(6);

        // Auto-increment fill of all 16 entries
        f0 = frame_cnt;
        tx_q = {8'h40};
        run_txn(0, 8'h00);
        tx_q = {8'hC0};
        for (int i = 0; i < 16; i++) tx_q.push_back(i[7:0]);
        run_txn(0, 8'h00);
        chk("frame_count_fill", frame_cnt - f0, 2);
        check_ram();

        // Fixed address: last byte wins
        tx_q = {8'h44};
        run_txn(0, 8'h00);
        tx_q = {8'hC5, 8'hAA, 8'hBB};
        run_txn(0, 8'h00);
        rd_ram(4'd5, d);
        chk("fixed_ram5", d, 8'hBB);
        check_ram();

        // Pointer wrap 15 -> 0
        tx_q = {8'h40};
        run_txn(0, 8'h00);
        tx_q = {8'hCF, 8'h11, 8'h22};
        run_txn(0, 8'h00);
        rd_ram(4'd15, d);
        chk("wrap_ram15", d, 8'h11);
        rd_ram(4'd0, d);
        chk("wrap_ram0", d, 8'h22);

        // Display control vector table
        for (int i = 0; i < 5; i++) begin
            tx_q = {dtab[i].cmd};
            run_txn(0, 8'h00);
            chk($sformatf("tab%0d_on", i), o_display_on, dtab[i].exp_on);
            chk($sformatf("tab%0d_br", i), o_brightness, dtab[i].exp_br);
        end

        // Key readback
        do_read(32'h8040_2001, got, oe_bad, tail);
        chk("key_byte0", got[7:0], 8'h01);
        chk("key_byte1", got[15:8], 8'h20);
        chk("key_byte2", got[23:16], 8'h40);
        chk("key_byte3", got[31:24], 8'h80);
        chk("key_tail_dio", tail, 1'b1);
        chk("key_oe_held", oe_bad, 0);
        end_read();

        // Partial byte discarded, then a complete write
        tx_q = {8'hC3};
        run_txn(5, 8'hFF);
        check_ram();
        tx_q = {8'hC3, 8'h5A};
        run_txn(0, 8'h00);
        rd_ram(4'd3, d);
        chk("ram3_5a", d, 8'h5A);

        // STB rise coincident with the 8th CLK rise must not write
        i_tm_stb = 1'b0;
        tick(H);
        send_bits(8'hC7, 8);
        send_bits(8'h3C, 7);
        i_tm_clk = 1'b0;
        i_dio    = 1'b0;
        tick(H);
        i_tm_clk = 1'b1;
        i_tm_stb = 1'b1;
        i_dio    = 1'b1;
        tick(2 * H);
        tx_q = {8'hC7};
        model_txn();
        rd_ram(4'd7, d);
        chk("simul_edge_ram7", d, m_ram[7]);

        // Randomized transactions against the model
        for (int it = 0; it < 24; it++) begin
            v = 8'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    v[7:6] = 2'b01;
                    v[1]   = 1'b0;
                    tx_q   = {v};
                end
                1: begin
                    v[7:6] = 2'b11;
                    tx_q   = {v};
                    n = $urandom_range(0, 4);
                    for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
                end
                default: begin
                    v[7:6] = 2'b10;
                    tx_q   = {v};
                end
            endcase
            run_txn($urandom_range(0, 7), 8'($urandom));
            check_disp();
            if (it % 6 == 5) check_ram();
        end

        for (int r = 0; r < 2; r++) begin
            keys = $urandom;
            do_read(keys, got, oe_bad, tail);
            chk("rand_keys", got, keys);
            chk("rand_tail", tail, 1'b1);
            end_read();
        end

        // Reset in the middle of a read, STB still low afterwards
        i_keys   = 32'hFFFF_FFFF;
        i_tm_stb = 1'b0;
        tick(H);
        send_bits(8'h42, 8);
        i_dio = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_tm_clk = 1'b0;
            tick(H);
            i_tm_clk = 1'b1;
            tick(H);
        end
        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        chk("rst_mid_oe", o_dio_oe, 1'b0);
        chk("rst_mid_dio", o_dio, 1'b1);
        m_ptr = 4'd0; m_fixed = 1'b0; m_on = 1'b0; m_br = 3'd0;
        tick(3);
        i_rst = 1'b0;
        tick(6);
        send_bits(8'hC3, 8);
        send_bits(8'h77, 8);
        i_dio    = 1'b1;
        i_tm_stb = 1'b1;
        tick(2 * H);
        check_disp();
        check_ram();
        tx_q = {8'hC3, 8'h99};
        run_txn(0, 8'h00);
        rd_ram(4'd3, d);
        chk("post_rst_ram3", d, 8'h99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
